// File: rtl/vga_fb_controller.sv
// vga_fb_controller: parametrised VGA timing, framebuffer scan-out and Wishbone slave with control/status registers.
module vga_fb_controller #(
  parameter int CLK_DIV     = 4,
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int COLOR_DEPTH = 8,
  parameter int PIXEL_MODE  = 2,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            data_i,
  output logic [31:0]            data_o,
  output logic                   ack_o,
  output logic [COLOR_DEPTH-1:0] vga_r,
  output logic [COLOR_DEPTH-1:0] vga_g,
  output logic [COLOR_DEPTH-1:0] vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int BW       = PIXEL_MODE == 0 ? 1 : PIXEL_MODE == 1 ? COLOR_DEPTH : 3 * COLOR_DEPTH;
  localparam int FB_W     = H_VISIBLE >> SCALE_SHIFT;
  localparam int FB_SIZE  = FB_W * (V_VISIBLE >> SCALE_SHIFT);
  localparam int AW       = FB_SIZE > 1 ? $clog2(FB_SIZE) : 1;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int DW       = CLK_DIV > 2 ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          fs_q, fs_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          en_q, en_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [2:0]    s1_q, s1_d, s2_q, s2_d;
  logic          ack_q, ack_d;
  logic [1:0]    rsel_q, rsel_d;
  logic [31:0]   reg_q, reg_d;
  logic          pix_ce, h_wrap, v_wrap, vis, hs_raw, vs_raw, in_vblank;
  logic          req, is_reg, in_rng, wr_pix, rd_pix, on;
  logic [28:0]   idx;
  logic [BW-1:0] mem [FB_SIZE];
  logic [BW-1:0] scan_q, bus_pix_q;
  logic [COLOR_DEPTH-1:0] r_px, g_px, b_px;
  logic          unused_ok;

  assign unused_ok = &{1'b0, addr_i[1:0], data_i};

  always_comb begin
    pix_ce    = div_q == DW'(CLK_DIV - 1);
    div_d     = pix_ce ? '0 : div_q + 1'b1;
    h_wrap    = h_q == HW'(H_TOTAL - 1);
    v_wrap    = v_q == VW'(V_TOTAL - 1);
    h_d       = !pix_ce ? h_q : h_wrap ? '0 : h_q + 1'b1;
    v_d       = !(pix_ce && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
    fs_d      = pix_ce && h_wrap && v_wrap;
    fcnt_d    = fcnt_q + 16'(fs_d);
    vis       = int'(h_q) < H_VISIBLE && int'(v_q) < V_VISIBLE;
    hs_raw    = int'(h_q) >= HS_START && int'(h_q) < HS_START + H_SYNC;
    vs_raw    = int'(v_q) >= VS_START && int'(v_q) < VS_START + V_SYNC;
    in_vblank = int'(v_q) >= V_VISIBLE;
    // Stage 1 latches the RAM address, stage 2 the RAM data; flags travel alongside.
    addr1_d   = !pix_ce ? addr1_q : vis ? AW'((int'(v_q) >> SCALE_SHIFT) * FB_W + (int'(h_q) >> SCALE_SHIFT)) : '0;
    s1_d      = pix_ce ? {vis, hs_raw, vs_raw} : s1_q;
    s2_d      = pix_ce ? s1_q : s2_q;
    req       = cyc_i && stb_i && !ack_q;
    idx       = addr_i[30:2];
    is_reg    = addr_i[31];
    in_rng    = {3'b0, idx} < 32'(FB_SIZE);
    wr_pix    = req && we_i && !is_reg && in_rng;
    rd_pix    = req && !we_i && !is_reg && in_rng;
    en_d      = (req && we_i && is_reg && idx == '0) ? data_i[0] : en_q;
    reg_d     = idx == 29'd0 ? {31'b0, en_q} : idx == 29'd1 ? {fcnt_q, 15'b0, in_vblank} : '0;
    ack_d     = req;
    rsel_d    = (!req || we_i) ? 2'd0 : is_reg ? 2'd2 : in_rng ? 2'd1 : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
      en_q    <= 1'b0;
      addr1_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      ack_q   <= 1'b0;
      rsel_q  <= '0;
      reg_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fs_q    <= fs_d;
      fcnt_q  <= fcnt_d;
      en_q    <= en_d;
      addr1_q <= addr1_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      ack_q   <= ack_d;
      rsel_q  <= rsel_d;
      reg_q   <= reg_d;
    end
  end

  // Read-before-write: a scan read of an entry being written sees the old value.
  always_ff @(posedge clk) begin
    if (wr_pix) mem[idx[AW-1:0]] <= data_i[BW-1:0];
    if (rd_pix) bus_pix_q <= mem[idx[AW-1:0]];
    if (pix_ce) scan_q <= mem[addr1_q];
  end

  if (PIXEL_MODE == 0) begin : g_mono
    assign r_px = {COLOR_DEPTH{scan_q[0]}};
    assign g_px = {COLOR_DEPTH{scan_q[0]}};
    assign b_px = {COLOR_DEPTH{scan_q[0]}};
  end else if (PIXEL_MODE == 1) begin : g_gray
    assign r_px = scan_q[COLOR_DEPTH-1:0];
    assign g_px = scan_q[COLOR_DEPTH-1:0];
    assign b_px = scan_q[COLOR_DEPTH-1:0];
  end else begin : g_rgb
    assign r_px = scan_q[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
    assign g_px = scan_q[2*COLOR_DEPTH-1:COLOR_DEPTH];
    assign b_px = scan_q[COLOR_DEPTH-1:0];
  end

  always_comb begin
    on          = s2_q[2] && en_q;
    vga_r       = on ? r_px : '0;
    vga_g       = on ? g_px : '0;
    vga_b       = on ? b_px : '0;
    hsync       = s2_q[1] ~^ SYNC_POL;
    vsync       = s2_q[0] ~^ SYNC_POL;
    frame_start = fs_q;
    ack_o       = ack_q;
    data_o      = rsel_q == 2'd1 ? 32'(bus_pix_q) : rsel_q == 2'd2 ? reg_q : '0;
  end
endmodule
